// File: rtl/pe_accumulator.sv
// -----------------------------------------------------------------------------
// pe_accumulator
//
// Output and accumulation stage of the processing element. It sits directly
// after the adder tree and holds the running two's-complement accumulator,
// which is fed back to the tree through acc_out. It accepts one tree result
// per input handshake for a programmed number of terms. It then presents the
// final sum in sign-magnitude form through an output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds its payload stable while valid=1 and ready=0.
// This block drives in_ready only from its state, and it holds out_valid,
// out_mag and out_sign stable until out_ready is seen.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request to begin a new accumulation (honoured only in IDLE)
//   len        number of terms, sampled with start
//   in_valid   tree_sum holds a valid term
//   in_ready   block accepts tree_sum this cycle (high in ACCUM)
//   tree_sum   adder tree result, computed from acc_out
//   acc_out    registered accumulator, feeds the adder tree
//   out_valid  result is presented (high in DONE)
//   out_ready  consumer takes the result
//   out_mag    unsigned magnitude of the result
//   out_sign   sign of the result, 1 = negative
//   busy       block is not in IDLE
// -----------------------------------------------------------------------------
module pe_accumulator #(
    parameter int ACC_W = 66,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] tree_sum,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_mag,
    output logic             out_sign,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] res;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic last_term;
    logic out_fire;

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    assign accept    = in_valid && in_ready;
    assign last_term = accept && (cnt == CNT_W'(1));
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            res   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // The result register is cleared as well, so a
                        // zero-length run presents exactly zero.
                        acc <= '0;
                        res <= '0;
                        if (len == '0) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= len;
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc <= tree_sum;
                        cnt <= cnt - CNT_W'(1);
                        if (last_term) begin
                            res   <= tree_sum;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // acc keeps the final sum after the handshake, so
                    // acc_out shows it until the next start.
                    if (out_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign acc_out  = acc;
    assign out_sign = res[ACC_W-1];
    // For the most negative value, negation wraps back to 100...0. That
    // pattern is the correct unsigned magnitude 2^(ACC_W-1).
    assign out_mag  = out_sign ? (~res + ACC_W'(1)) : res;

endmodule
